richie_ctrl_seq: RTL and testbench

- Instruction sequencer for Richie Jr.
- Drives the 4-bit program counter (increment, load, clear), the instruction register, the accumulator/ALU controls and the data memory strobes.
- Executes one instruction per three-cycle FETCH/DECODE/EXEC sequence, in free-run or single-step mode.
- Sits between the front-panel run/step/clear inputs and the datapath.

---
 rtl/richie_ctrl_seq.sv | 139 +++++++++++++
 tb/tb_richie_ctrl_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/richie_ctrl_seq.sv
// Richie Jr. instruction sequencer: runs a FETCH/DECODE/EXEC cycle per instruction
// and drives the PC, instruction register, accumulator/ALU and data-memory strobes.
module richie_ctrl_seq #(
  parameter int ADDRW = 4,
  parameter int OPW   = 4
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 run,
  input  logic                 step,
  input  logic                 clr,
  input  logic [OPW+ADDRW-1:0] instr,
  input  logic                 zero_flag,
  input  logic                 carry_flag,
  output logic                 pc_res,
  output logic                 pc_en,
  output logic                 pc_load,
  output logic [ADDRW-1:0]     pc_load_val,
  output logic                 ir_load,
  output logic                 acc_load,
  output logic [2:0]           alu_op,
  output logic                 mem_rd,
  output logic                 mem_we,
  output logic                 halted,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_FETCH  = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [OPW-1:0] OP_NOP = OPW'(4'h0);
  localparam logic [OPW-1:0] OP_LDI = OPW'(4'h1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(4'h2);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'h3);
  localparam logic [OPW-1:0] OP_AND = OPW'(4'h4);
  localparam logic [OPW-1:0] OP_OR  = OPW'(4'h5);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4'h6);
  localparam logic [OPW-1:0] OP_JMP = OPW'(4'h7);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(4'h8);
  localparam logic [OPW-1:0] OP_JC  = OPW'(4'h9);
  localparam logic [OPW-1:0] OP_STA = OPW'(4'hA);
  localparam logic [OPW-1:0] OP_LDA = OPW'(4'hB);
  localparam logic [OPW-1:0] OP_HLT = OPW'(4'hF);

  state_e           state_q, state_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [ADDRW-1:0] arg_q, arg_d;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= S_INIT;
      op_q    <= '0;
      arg_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    arg_d    = arg_q;
    pc_res   = 1'b0;
    pc_en    = 1'b0;
    pc_load  = 1'b0;
    ir_load  = 1'b0;
    acc_load = 1'b0;
    alu_op   = 3'd0;
    mem_rd   = 1'b0;
    mem_we   = 1'b0;
    halted   = 1'b0;

    case (state_q)
      S_INIT: begin
        pc_res  = 1'b1;
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (run || step) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_load = 1'b1;
        op_d    = instr[OPW+ADDRW-1:ADDRW];
        arg_d   = instr[ADDRW-1:0];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        mem_rd  = (op_q == OP_LDA);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = run ? S_FETCH : S_IDLE;
        // A restart abandons the instruction: no architectural side effects this cycle.
        if (!clr) begin
          case (op_q)
            OP_LDI: begin acc_load = 1'b1; alu_op = 3'd0; pc_en = 1'b1; end
            OP_ADD: begin acc_load = 1'b1; alu_op = 3'd1; pc_en = 1'b1; end
            OP_SUB: begin acc_load = 1'b1; alu_op = 3'd2; pc_en = 1'b1; end
            OP_AND: begin acc_load = 1'b1; alu_op = 3'd3; pc_en = 1'b1; end
            OP_OR:  begin acc_load = 1'b1; alu_op = 3'd4; pc_en = 1'b1; end
            OP_XOR: begin acc_load = 1'b1; alu_op = 3'd5; pc_en = 1'b1; end
            OP_JMP: pc_load = 1'b1;
            OP_JZ: begin
              pc_load = zero_flag;
              pc_en   = !zero_flag;
            end
            OP_JC: begin
              pc_load = carry_flag;
              pc_en   = !carry_flag;
            end
            OP_STA: begin mem_we = 1'b1; pc_en = 1'b1; end
            OP_LDA: begin acc_load = 1'b1; alu_op = 3'd6; pc_en = 1'b1; end
            OP_HLT: state_d = S_HALT;
            OP_NOP: pc_en = 1'b1;
            default: pc_en = 1'b1;
          endcase
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_INIT;
    endcase

    if (clr) state_d = S_INIT;
  end

  assign pc_load_val = arg_q;
  assign state       = state_q;

endmodule

// File: tb/tb_richie_ctrl_seq.sv
// Bench for richie_ctrl_seq: table of per-cycle {inputs, expected outputs} plus
// hand-written halt / clear / reset sequences, checked through an expectation queue.
module tb_richie_ctrl_seq;

  logic       clk = 1'b0;
  logic       res_n, run, step, clr, zero_flag, carry_flag;
  logic [7:0] instr;
  logic       pc_res, pc_en, pc_load, ir_load, acc_load, mem_rd, mem_we, halted;
  logic [3:0] pc_load_val;
  logic [2:0] alu_op, state;

  always #5 clk = ~clk;

  richie_ctrl_seq #(.ADDRW(4), .OPW(4)) dut (
    .clk(clk), .res_n(res_n), .run(run), .step(step), .clr(clr), .instr(instr),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .pc_res(pc_res), .pc_en(pc_en),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .ir_load(ir_load),
    .acc_load(acc_load), .alu_op(alu_op), .mem_rd(mem_rd), .mem_we(mem_we),
    .halted(halted), .state(state)
  );

  // Strobe bit positions: {pc_res, pc_en, pc_load, ir_load, acc_load, mem_rd, mem_we, halted}
  localparam logic [7:0] PR = 8'h80, PE = 8'h40, PL = 8'h20, IR = 8'h10;
  localparam logic [7:0] AL = 8'h08, MR = 8'h04, MW = 8'h02, HT = 8'h01;

  typedef struct packed {
    logic [7:0] strb;
    logic [2:0] alu;
    logic [3:0] val;
    logic [2:0] st;
  } out_t;

  typedef struct {
    string      name;
    logic       run, step, clr, zf, cf;
    logic [7:0] instr;
    out_t       exp;
  } vec_t;

  vec_t tbl[$];
  out_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic vec_t mkv(string nm, logic r, logic s, logic c, logic [7:0] i,
                               logic z, logic cy, logic [2:0] st, logic [7:0] sb,
                               logic [2:0] a = 3'd0, logic [3:0] v = 4'd0);
    vec_t t;
    t.name = nm; t.run = r; t.step = s; t.clr = c; t.instr = i; t.zf = z; t.cf = cy;
    t.exp.strb = sb; t.exp.alu = a; t.exp.val = v; t.exp.st = st;
    return t;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.strb = {pc_res, pc_en, pc_load, ir_load, acc_load, mem_rd, mem_we, halted};
    o.alu  = alu_op;
    o.val  = pc_load_val;
    o.st   = state;
    return o;
  endfunction

  // Pops the oldest expectation and compares it with the current outputs.
  // pc_load_val is only meaningful while pc_load is expected.
  task automatic check(string nm);
    out_t e, a;
    bit   ok;
    a = sample();
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expectation queued, got %h", nm, a);
      return;
    end
    e  = exp_q.pop_front();
    ok = (a.strb == e.strb) && (a.alu == e.alu) && (a.st == e.st) &&
         (!e.strb[5] || a.val == e.val);
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got strb=%h alu=%0d val=%h state=%0d, want strb=%h alu=%0d val=%h state=%0d",
               nm, a.strb, a.alu, a.val, a.st, e.strb, e.alu, e.val, e.st);
    end
  endtask

  task automatic chk_now(vec_t v);
    exp_q.push_back(v.exp);
    #1;
    check(v.name);
  endtask

  // Called at a falling edge: drive, check mid-cycle, advance to next falling edge.
  task automatic cyc(vec_t v);
    run = v.run; step = v.step; clr = v.clr; instr = v.instr;
    zero_flag = v.zf; carry_flag = v.cf;
    chk_now(v);
    @(negedge clk);
  endtask

  task automatic chk_val0(string nm);
    n_chk++;
    if (pc_load_val !== 4'h0) begin
      n_fail++;
      $display("FAIL %s: pc_load_val got %h want 0", nm, pc_load_val);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] alu_ins [4];
  logic [2:0] alu_exp [4];

  initial begin
    alu_ins = '{8'h46, 8'h52, 8'h63, 8'h31};
    alu_exp = '{3'd3, 3'd4, 3'd5, 3'd2};

    // Reset release and LDI under run
    tbl.push_back(mkv("rst_init",   0,0,0,8'h00,0,0,3'd0,PR));
    tbl.push_back(mkv("idle_a",     0,0,0,8'h00,0,0,3'd1,8'h00));
    tbl.push_back(mkv("idle_b",     0,0,0,8'h15,0,0,3'd1,8'h00));
    tbl.push_back(mkv("ldi_idle",   1,0,0,8'h15,0,0,3'd1,8'h00));
    tbl.push_back(mkv("ldi_fetch",  1,0,0,8'h15,0,0,3'd2,IR));
    tbl.push_back(mkv("ldi_dec",    1,0,0,8'h15,0,0,3'd3,8'h00));
    tbl.push_back(mkv("ldi_exec",   1,0,0,8'h15,0,0,3'd4,PE|AL,3'd0));
    // ADD with run falling during EXEC
    tbl.push_back(mkv("add_fetch",  1,0,0,8'h21,0,0,3'd2,IR));
    tbl.push_back(mkv("add_dec",    1,0,0,8'h21,0,0,3'd3,8'h00));
    tbl.push_back(mkv("add_exec",   0,0,0,8'h21,0,0,3'd4,PE|AL,3'd1));
    tbl.push_back(mkv("add_idle",   0,0,0,8'h21,0,0,3'd1,8'h00));
    // Single-step JMP 10
    tbl.push_back(mkv("jmp_idle",   0,1,0,8'h7A,0,0,3'd1,8'h00));
    tbl.push_back(mkv("jmp_fetch",  0,0,0,8'h7A,0,0,3'd2,IR));
    tbl.push_back(mkv("jmp_dec",    0,0,0,8'h7A,0,0,3'd3,8'h00));
    tbl.push_back(mkv("jmp_exec",   0,0,0,8'h7A,0,0,3'd4,PL,3'd0,4'hA));
    tbl.push_back(mkv("jmp_idle2",  0,0,0,8'h7A,0,0,3'd1,8'h00));
    tbl.push_back(mkv("jmp_idle3",  0,0,0,8'h7A,0,0,3'd1,8'h00));
    // JZ 3 not taken, then taken (flag only matters in EXEC)
    tbl.push_back(mkv("jz0_idle",   0,1,0,8'h83,0,0,3'd1,8'h00));
    tbl.push_back(mkv("jz0_fetch",  0,0,0,8'h83,0,0,3'd2,IR));
    tbl.push_back(mkv("jz0_dec",    0,0,0,8'h83,1,0,3'd3,8'h00));
    tbl.push_back(mkv("jz0_exec",   0,0,0,8'h83,0,0,3'd4,PE));
    tbl.push_back(mkv("jz0_end",    0,0,0,8'h83,0,0,3'd1,8'h00));
    tbl.push_back(mkv("jz1_idle",   0,1,0,8'h83,0,0,3'd1,8'h00));
    tbl.push_back(mkv("jz1_fetch",  0,0,0,8'h83,0,0,3'd2,IR));
    tbl.push_back(mkv("jz1_dec",    0,0,0,8'h83,0,0,3'd3,8'h00));
    tbl.push_back(mkv("jz1_exec",   0,0,0,8'h83,1,0,3'd4,PL,3'd0,4'h3));
    tbl.push_back(mkv("jz1_end",    0,0,0,8'h83,0,0,3'd1,8'h00));
    // Back-to-back run: JC taken, LDA, STA, JC not taken
    tbl.push_back(mkv("jc1_idle",   1,0,0,8'h9C,0,0,3'd1,8'h00));
    tbl.push_back(mkv("jc1_fetch",  1,0,0,8'h9C,0,0,3'd2,IR));
    tbl.push_back(mkv("jc1_dec",    1,0,0,8'h9C,0,0,3'd3,8'h00));
    tbl.push_back(mkv("jc1_exec",   1,0,0,8'h9C,1,1,3'd4,PL,3'd0,4'hC));
    tbl.push_back(mkv("lda_fetch",  1,0,0,8'hB5,0,0,3'd2,IR));
    tbl.push_back(mkv("lda_dec",    1,0,0,8'hB5,0,0,3'd3,MR));
    tbl.push_back(mkv("lda_exec",   1,0,0,8'hB5,0,0,3'd4,PE|AL,3'd6));
    tbl.push_back(mkv("sta_fetch",  1,0,0,8'hA7,0,0,3'd2,IR));
    tbl.push_back(mkv("sta_dec",    1,0,0,8'hA7,0,0,3'd3,8'h00));
    tbl.push_back(mkv("sta_exec",   1,0,0,8'hA7,0,0,3'd4,PE|MW));
    tbl.push_back(mkv("jc0_fetch",  1,0,0,8'h93,0,0,3'd2,IR));
    tbl.push_back(mkv("jc0_dec",    1,0,0,8'h93,0,1,3'd3,8'h00));
    tbl.push_back(mkv("jc0_exec",   1,0,0,8'h93,1,0,3'd4,PE));
    for (int k = 0; k < 4; k++) begin
      tbl.push_back(mkv("alu_fetch", 1,0,0,alu_ins[k],0,0,3'd2,IR));
      tbl.push_back(mkv("alu_dec",   1,0,0,alu_ins[k],0,0,3'd3,8'h00));
      tbl.push_back(mkv("alu_exec",  1,0,0,alu_ins[k],0,0,3'd4,PE|AL,alu_exp[k]));
    end
    tbl.push_back(mkv("nopc_fetch", 1,0,0,8'hC0,0,0,3'd2,IR));
    tbl.push_back(mkv("nopc_dec",   1,0,0,8'hC0,0,0,3'd3,8'h00));
    tbl.push_back(mkv("nopc_exec",  0,0,0,8'hC0,0,0,3'd4,PE));
    // step held high re-triggers each time IDLE is reached
    tbl.push_back(mkv("sh_idle",    0,1,0,8'h00,0,0,3'd1,8'h00));
    tbl.push_back(mkv("sh_fetch",   0,1,0,8'h00,0,0,3'd2,IR));
    tbl.push_back(mkv("sh_dec",     0,1,0,8'h00,0,0,3'd3,8'h00));
    tbl.push_back(mkv("sh_exec",    0,1,0,8'h00,0,0,3'd4,PE));
    tbl.push_back(mkv("sh_idle2",   0,1,0,8'h00,0,0,3'd1,8'h00));
    tbl.push_back(mkv("sh_fetch2",  0,0,0,8'h00,0,0,3'd2,IR));
    tbl.push_back(mkv("sh_dec2",    0,0,0,8'h00,0,0,3'd3,8'h00));
    tbl.push_back(mkv("sh_exec2",   0,0,0,8'h00,0,0,3'd4,PE));
    // run and step together behave as run
    tbl.push_back(mkv("rs_idle",    1,1,0,8'h15,0,0,3'd1,8'h00));
    tbl.push_back(mkv("rs_fetch",   1,1,0,8'h15,0,0,3'd2,IR));
    tbl.push_back(mkv("rs_dec",     1,1,0,8'h15,0,0,3'd3,8'h00));
    tbl.push_back(mkv("rs_exec",    1,1,0,8'h15,0,0,3'd4,PE|AL,3'd0));
    tbl.push_back(mkv("rs_fetch2",  0,0,0,8'h15,0,0,3'd2,IR));
    tbl.push_back(mkv("rs_dec2",    0,0,0,8'h15,0,0,3'd3,8'h00));
    tbl.push_back(mkv("rs_exec2",   0,0,0,8'h15,0,0,3'd4,PE|AL,3'd0));
    tbl.push_back(mkv("rs_idle2",   0,0,0,8'h15,0,0,3'd1,8'h00));

    // Reset: outputs at reset values even with run high
    res_n = 1'b0; run = 1'b1; step = 1'b0; clr = 1'b0; instr = 8'hFF;
    zero_flag = 1'b0; carry_flag = 1'b0;
    @(negedge clk);
    chk_now(mkv("in_reset", 1,0,0,8'hFF,0,0,3'd0,PR));
    chk_val0("in_reset_val");
    @(negedge clk);
    res_n = 1'b1;

    foreach (tbl[k]) cyc(tbl[k]);

    // HLT under run: HALT holds against run/step, clr exits
    cyc(mkv("hlt_idle",  1,0,0,8'hF0,0,0,3'd1,8'h00));
    cyc(mkv("hlt_fetch", 1,0,0,8'hF0,0,0,3'd2,IR));
    cyc(mkv("hlt_dec",   1,0,0,8'hF0,0,0,3'd3,8'h00));
    cyc(mkv("hlt_exec",  1,0,0,8'hF0,0,0,3'd4,8'h00));
    for (int k = 0; k < 20; k++)
      cyc(mkv("halt_hold", 1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 0,
              8'h15, 0, 0, 3'd5, HT));
    cyc(mkv("halt_clr",  1,1,1,8'h15,0,0,3'd5,HT));
    cyc(mkv("clr_init",  0,0,0,8'h15,0,0,3'd0,PR));
    cyc(mkv("clr_idle",  0,0,0,8'h15,0,0,3'd1,8'h00));

    // clr during EXEC of ADD abandons the instruction
    cyc(mkv("cadd_idle",  1,0,0,8'h21,0,0,3'd1,8'h00));
    cyc(mkv("cadd_fetch", 1,0,0,8'h21,0,0,3'd2,IR));
    cyc(mkv("cadd_dec",   1,0,0,8'h21,0,0,3'd3,8'h00));
    cyc(mkv("cadd_exec",  1,0,1,8'h21,0,0,3'd4,8'h00));
    cyc(mkv("cadd_init",  0,0,0,8'h21,0,0,3'd0,PR));
    cyc(mkv("cadd_idle2", 0,0,0,8'h21,0,0,3'd1,8'h00));

    // Asynchronous reset in the middle of an LDA DECODE
    cyc(mkv("rlda_idle",  1,0,0,8'hB5,0,0,3'd1,8'h00));
    cyc(mkv("rlda_fetch", 1,0,0,8'hB5,0,0,3'd2,IR));
    chk_now(mkv("rlda_dec", 1,0,0,8'hB5,0,0,3'd3,MR));
    #1;
    res_n = 1'b0;
    chk_now(mkv("rlda_rst", 1,0,0,8'hB5,0,0,3'd0,PR));
    chk_val0("rlda_rst_val");
    @(negedge clk);
    res_n = 1'b1;
    cyc(mkv("rlda_init", 0,0,0,8'hB5,0,0,3'd0,PR));
    cyc(mkv("rlda_idle2",0,0,0,8'hB5,0,0,3'd1,8'h00));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
